// File: rtl/gbuff_arb_pkg.sv
// rtl/gbuff_arb_pkg.sv - shared types and constants for the global-buffer port arbiter
package gbuff_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam int PORT_CPU         = 0;
    localparam int PORT_TPU         = 1;
    localparam int DEF_STARVE_LIMIT = 16;

endpackage

// File: rtl/gbuff_port_arbiter_if.sv
// rtl/gbuff_port_arbiter_if.sv - requester ports and buffer drive bundled for one arbiter
interface gbuff_port_arbiter_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    logic                 p0_req;
    logic                 p0_lock;
    logic                 p0_we;
    logic [ADDR_BITS-1:0] p0_index;
    logic [DATA_BITS-1:0] p0_wdata;
    logic                 p0_gnt;
    logic                 p0_rvalid;
    logic [DATA_BITS-1:0] p0_rdata;

    logic                 p1_req;
    logic                 p1_lock;
    logic                 p1_we;
    logic [ADDR_BITS-1:0] p1_index;
    logic [DATA_BITS-1:0] p1_wdata;
    logic                 p1_gnt;
    logic                 p1_rvalid;
    logic [DATA_BITS-1:0] p1_rdata;

    logic                 buf_wr_en;
    logic [ADDR_BITS-1:0] buf_index;
    logic [DATA_BITS-1:0] buf_data_in;
    logic [DATA_BITS-1:0] buf_data_out;

    // Requesters plus the buffer itself
    modport master (
        output p0_req, p0_lock, p0_we, p0_index, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_lock, p1_we, p1_index, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  buf_wr_en, buf_index, buf_data_in,
        output buf_data_out
    );

    modport slave (
        input  p0_req, p0_lock, p0_we, p0_index, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_lock, p1_we, p1_index, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output buf_wr_en, buf_index, buf_data_in,
        input  buf_data_out
    );

endinterface

// File: rtl/gbuff_starve_ctr.sv
// rtl/gbuff_starve_ctr.sv - saturating denied-cycle counter that forces a port-0 grant
module gbuff_starve_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_force
);

    localparam logic [7:0] LIM = 8'(LIMIT);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != LIM) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_force = i_req && (r_cnt == LIM);

endmodule

// File: rtl/gbuff_port_arbiter.sv
// rtl/gbuff_port_arbiter.sv - two-port arbiter in front of one single-port global buffer
// Optional starvation guard for port 0 enabled by GBUFF_ARB_STARVE_EN.
module gbuff_port_arbiter
    import gbuff_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 32
`ifdef GBUFF_ARB_STARVE_EN
   ,parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    gbuff_port_arbiter_if.slave  bus
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [1:0]           w_gnt;
    logic                 w_force;
    logic                 w_buf_wr_en;
    logic [ADDR_BITS-1:0] w_buf_index;
    logic [DATA_BITS-1:0] w_buf_data;
    logic [ADDR_BITS-1:0] r_last_index;
    logic [DATA_BITS-1:0] r_last_data;
    logic [1:0]           r_rvalid;

`ifdef GBUFF_ARB_STARVE_EN
    gbuff_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .reset   (reset),
        .i_req   (bus.p0_req),
        .i_gnt   (w_gnt[PORT_CPU]),
        .o_force (w_force)
    );
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are gated by reset so nothing reaches the buffer while reset is high
    always_comb begin
        w_gnt       = 2'b00;
        w_state_nxt = r_state;
        if (!reset) begin
            if (w_force) begin
                w_gnt[PORT_CPU] = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.p1_req)      w_gnt[PORT_TPU] = 1'b1;
                        else if (bus.p0_req) w_gnt[PORT_CPU] = 1'b1;
                    end
                    ST_OWN0: w_gnt[PORT_CPU] = bus.p0_req;
                    ST_OWN1: w_gnt[PORT_TPU] = bus.p1_req;
                    default: w_gnt = 2'b00;
                endcase
            end

            // A forced port-0 grant never takes or drops ownership by itself
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt[PORT_TPU] && bus.p1_lock)
                        w_state_nxt = ST_OWN1;
                    else if (w_gnt[PORT_CPU] && bus.p0_lock && !w_force)
                        w_state_nxt = ST_OWN0;
                end
                ST_OWN0: begin
                    if (!bus.p0_req || (w_gnt[PORT_CPU] && !bus.p0_lock))
                        w_state_nxt = ST_IDLE;
                end
                ST_OWN1: begin
                    if (!bus.p1_req || (w_gnt[PORT_TPU] && !bus.p1_lock))
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_buf_wr_en = (w_gnt[PORT_CPU] && bus.p0_we) || (w_gnt[PORT_TPU] && bus.p1_we);
        w_buf_index = r_last_index;
        w_buf_data  = r_last_data;
        if (w_gnt[PORT_TPU]) begin
            w_buf_index = bus.p1_index;
            w_buf_data  = bus.p1_wdata;
        end else if (w_gnt[PORT_CPU]) begin
            w_buf_index = bus.p0_index;
            w_buf_data  = bus.p0_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_index <= '0;
            r_last_data  <= '0;
            r_rvalid     <= 2'b00;
        end else begin
            if (|w_gnt) begin
                r_last_index <= w_buf_index;
                r_last_data  <= w_buf_data;
            end
            r_rvalid <= w_gnt & ~{bus.p1_we, bus.p0_we};
        end
    end

    assign bus.p0_gnt      = w_gnt[PORT_CPU];
    assign bus.p1_gnt      = w_gnt[PORT_TPU];
    assign bus.p0_rvalid   = r_rvalid[PORT_CPU];
    assign bus.p1_rvalid   = r_rvalid[PORT_TPU];
    assign bus.p0_rdata    = bus.buf_data_out;
    assign bus.p1_rdata    = bus.buf_data_out;
    assign bus.buf_wr_en   = w_buf_wr_en;
    assign bus.buf_index   = w_buf_index;
    assign bus.buf_data_in = w_buf_data;

endmodule

// File: tb/tb_gbuff_port_arbiter.sv
// tb/tb_gbuff_port_arbiter.sv - directed and random checks of gbuff_port_arbiter against a reference model
module tb_gbuff_port_arbiter;
    import gbuff_arb_pkg::*;

    localparam int AB = 8;
    localparam int DB = 32;
`ifdef GBUFF_ARB_STARVE_EN
    localparam int LIM = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gbuff_port_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    gbuff_port_arbiter #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB)
`ifdef GBUFF_ARB_STARVE_EN
       ,.STARVE_LIMIT(LIM)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Global buffer: synchronous write, registered read
    logic [DB-1:0] bmem [256];
    always @(posedge clk) begin
        if (bus.buf_wr_en) bmem[bus.buf_index] <= bus.buf_data_in;
        bus.buf_data_out <= bmem[bus.buf_index];
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner is -1 (none), 0 or 1
    int            m_owner;
    int            m_cnt;
    logic          m_rv0, m_rv1;
    logic [DB-1:0] m_rd;
    logic [DB-1:0] m_mem [256];
    logic [AB-1:0] m_lidx;
    logic [DB-1:0] m_ldat;
    logic          e0, e1, ewe, efrc;
    logic [AB-1:0] ei;
    logic [DB-1:0] ed;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic req, input logic lock, input logic we,
                       input logic [AB-1:0] idx, input logic [DB-1:0] d);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_lock = lock; bus.p0_we = we;
            bus.p0_index = idx; bus.p0_wdata = d;
        end else begin
            bus.p1_req = req; bus.p1_lock = lock; bus.p1_we = we;
            bus.p1_index = idx; bus.p1_wdata = d;
        end
    endtask

    task automatic sample();
        #1;
        if (reset) begin
            m_owner = -1; m_cnt = 0; m_rv0 = 1'b0; m_rv1 = 1'b0;
            m_lidx = '0; m_ldat = '0;
        end
        efrc = 1'b0;
`ifdef GBUFF_ARB_STARVE_EN
        efrc = (m_cnt == LIM) && bus.p0_req;
`endif
        e0 = 1'b0; e1 = 1'b0;
        if (!reset) begin
            if (efrc)               e0 = 1'b1;
            else if (m_owner == 1)  e1 = bus.p1_req;
            else if (m_owner == 0)  e0 = bus.p0_req;
            else begin
                e1 = bus.p1_req;
                e0 = bus.p0_req && !bus.p1_req;
            end
        end
        ewe = (e0 && bus.p0_we) || (e1 && bus.p1_we);
        ei  = e1 ? bus.p1_index : (e0 ? bus.p0_index : m_lidx);
        ed  = e1 ? bus.p1_wdata : (e0 ? bus.p0_wdata : m_ldat);
        chk("p0_gnt", bus.p0_gnt, e0);
        chk("p1_gnt", bus.p1_gnt, e1);
        chk("buf_wr_en", bus.buf_wr_en, ewe);
        chk("buf_index", bus.buf_index, ei);
        chk("buf_data_in", bus.buf_data_in, ed);
        chk("p0_rvalid", bus.p0_rvalid, m_rv0);
        chk("p1_rvalid", bus.p1_rvalid, m_rv1);
        if (m_rv0) chk("p0_rdata", bus.p0_rdata, m_rd);
        if (m_rv1) chk("p1_rdata", bus.p1_rdata, m_rd);
    endtask

    task automatic adv();
        @(posedge clk);
        if (!reset) begin
            m_rv0 = e0 && !bus.p0_we;
            m_rv1 = e1 && !bus.p1_we;
            if (m_rv0 || m_rv1) m_rd = m_mem[ei];
            if (ewe) m_mem[ei] = ed;
            if (e0 || e1) begin m_lidx = ei; m_ldat = ed; end
            if (m_owner == -1) begin
                if (e1 && bus.p1_lock)                 m_owner = 1;
                else if (e0 && bus.p0_lock && !efrc)   m_owner = 0;
            end else if (m_owner == 0) begin
                if (!bus.p0_req || (e0 && !bus.p0_lock)) m_owner = -1;
            end else begin
                if (!bus.p1_req || (e1 && !bus.p1_lock)) m_owner = -1;
            end
`ifdef GBUFF_ARB_STARVE_EN
            if (!bus.p0_req || e0) m_cnt = 0;
            else if (m_cnt < LIM)  m_cnt = m_cnt + 1;
`endif
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    logic          pq [2];
    logic          pl [2];
    logic          pw [2];
    logic [AB-1:0] pi [2];
    logic [DB-1:0] pd [2];

    initial begin
        for (int i = 0; i < 256; i++) begin bmem[i] = '0; m_mem[i] = '0; end
        m_owner = -1; m_cnt = 0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd = '0;
        m_lidx = '0; m_ldat = '0;
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        bus.buf_data_out = '0;

        // Reset state, with a request pending that must not be granted
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 1'b1, 8'd9, 32'h11111111);
        cyc();
        chk("rst_state", dut.r_state, ST_IDLE);
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;

        // p0 write then read back
        drv(0, 1'b1, 1'b0, 1'b1, 8'd5, 32'hDEADBEEF);
        cyc();
        drv(0, 1'b1, 1'b0, 1'b0, 8'd5, 32'h0);
        sample(); chk("t1_rd_gnt", bus.p0_gnt, 1'b1); adv();
        drv(0, 1'b0, 1'b0, 1'b0, 8'd5, 32'h0);
        sample();
        chk("t1_rvalid", bus.p0_rvalid, 1'b1);
        chk("t1_rdata", bus.p0_rdata, 32'hDEADBEEF);
        chk("t1_p1_rvalid", bus.p1_rvalid, 1'b0);
        adv();

        // Simultaneous reads in IDLE: TPU first
        drv(0, 1'b1, 1'b0, 1'b0, 8'd3, '0);
        drv(1, 1'b1, 1'b0, 1'b0, 8'd7, '0);
        sample(); chk("t2_p1_first", bus.p1_gnt, 1'b1); adv();
        drv(1, 1'b0, 1'b0, 1'b0, 8'd7, '0);
        sample(); chk("t2_p0_second", bus.p0_gnt, 1'b1); adv();
        drv(0, 1'b0, 1'b0, 1'b0, 8'd3, '0);
        cyc();

        // p1 locked burst while p0 waits
        drv(0, 1'b1, 1'b0, 1'b0, 8'd9, '0);
        for (int k = 0; k < 4; k++) begin
            drv(1, 1'b1, 1'b1, 1'b0, AB'(10 + k), '0);
            cyc();
        end
        drv(1, 1'b1, 1'b0, 1'b0, 8'd14, '0);
        cyc();
        drv(1, 1'b0, 1'b0, 1'b0, 8'd14, '0);
        sample(); chk("t3_p0_after", bus.p0_gnt, 1'b1); adv();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc();

`ifdef GBUFF_ARB_STARVE_EN
        // Starvation override inside OWN1
        drv(0, 1'b1, 1'b0, 1'b0, 8'd5, '0);
        drv(1, 1'b1, 1'b1, 1'b0, 8'd20, '0);
        for (int k = 0; k < 4; k++) cyc();
        sample(); chk("st_forced", bus.p0_gnt, 1'b1); adv();
        chk("st_own1", dut.r_state, ST_OWN1);
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        sample(); chk("st_p1_again", bus.p1_gnt, 1'b1); adv();
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc();
`endif

        // Reset right after a locked p1 read grant
        drv(1, 1'b1, 1'b1, 1'b0, 8'd7, '0);
        cyc();
        reset = 1'b1;
        drv(0, 1'b1, 1'b0, 1'b1, 8'd5, 32'h12345678);
        sample();
        chk("rm_p1_rvalid", bus.p1_rvalid, 1'b0);
        chk("rm_state", dut.r_state, ST_IDLE);
        adv();
        reset = 1'b0;
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(0, 1'b1, 1'b0, 1'b0, 8'd5, '0);
        cyc();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        sample(); chk("rm_rdata", bus.p0_rdata, 32'hDEADBEEF); adv();

        // Random traffic obeying hold-until-granted
        for (int p = 0; p < 2; p++) begin
            pq[p] = 1'b0; pl[p] = 1'b0; pw[p] = 1'b0; pi[p] = '0; pd[p] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pq[p] && ($urandom_range(0, 3) != 0)) begin
                    pq[p] = 1'b1;
                    pl[p] = ($urandom_range(0, 2) == 0);
                    pw[p] = $urandom_range(0, 1) == 1;
                    pi[p] = AB'($urandom_range(0, 15));
                    pd[p] = DB'($urandom);
                end
                drv(p, pq[p], pl[p], pw[p], pi[p], pd[p]);
            end
            reset = ($urandom_range(0, 96) == 0);
            sample();
            if (e0) pq[0] = 1'b0;
            if (e1) pq[1] = 1'b0;
            adv();
        end
        reset = 1'b0;
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
